// File: rtl/neuron_spike_ctrl.sv
// Spike sequencing controller for the emulated exponential neuron: threshold detect,
// reset/refractory sequencing, and a timestamped spike-event FIFO toward consumers.
module neuron_spike_ctrl #(
  parameter int WIDTH          = 16,
  parameter int TS_W           = 24,
  parameter int CNT_W          = 16,
  parameter int RESET_CYCLES   = 2,
  parameter int REFRACT_CYCLES = 5,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] v_mem,
  input  logic signed [WIDTH-1:0] v_thresh,
  output logic                    v_set,
  output logic                    hold,
  output logic                    busy,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic [TS_W-1:0]         spike_time,
  output logic [CNT_W-1:0]        spike_count,
  output logic                    overflow
);

  localparam int         AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CW          = AW + 1;
  localparam logic [7:0] RST_LOAD    = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] REF_LOAD    = 8'((REFRACT_CYCLES > 0) ? REFRACT_CYCLES - 1 : 0);
  localparam bit         HAS_REFRACT = (REFRACT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, INTEGRATE, SPIKE, REFRACT} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  state_t            state, state_d;
  logic [7:0]        seq_cnt, seq_cnt_d;
  logic              detect;
  logic [TS_W-1:0]   ts;

  logic [TS_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt, fifo_cnt_d;
  logic              full, pop, push_ok;
  logic [TS_W-1:0]   spike_time_d;

  // Sequencer: seq_cnt counts down the remaining cycles of SPIKE or REFRACT.
  always_comb begin
    state_d   = state;
    seq_cnt_d = seq_cnt;
    detect    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_d = INTEGRATE;
      end
      INTEGRATE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (v_mem >= v_thresh) begin
          detect    = 1'b1;
          state_d   = SPIKE;
          seq_cnt_d = RST_LOAD;
        end
      end
      SPIKE: begin
        if (seq_cnt == 8'd0) begin
          if (HAS_REFRACT) begin
            state_d   = REFRACT;
            seq_cnt_d = REF_LOAD;
          end else begin
            state_d = en ? INTEGRATE : IDLE;
          end
        end else begin
          seq_cnt_d = seq_cnt - 8'd1;
        end
      end
      REFRACT: begin
        if (seq_cnt == 8'd0) state_d = en ? INTEGRATE : IDLE;
        else                 seq_cnt_d = seq_cnt - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head pops the same cycle.
  always_comb begin
    full       = (fifo_cnt == CW'(FIFO_DEPTH));
    pop        = spike_valid & spike_ready;
    push_ok    = detect & (~full | pop);
    rd_ptr_d   = pop ? rd_ptr + AW'(1) : rd_ptr;
    fifo_cnt_d = fifo_cnt;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt - CW'(1);
      default: fifo_cnt_d = fifo_cnt;
    endcase
    if (fifo_cnt_d == '0)
      spike_time_d = spike_time;
    else if (fifo_cnt == '0 || (fifo_cnt == CW'(1) && pop))
      spike_time_d = ts;
    else
      spike_time_d = fifo_mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      seq_cnt     <= 8'd0;
      v_set       <= 1'b0;
      hold        <= 1'b0;
      busy        <= 1'b0;
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      spike_valid <= 1'b0;
      spike_time  <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_d;
      seq_cnt     <= seq_cnt_d;
      v_set       <= (state_d == SPIKE);
      hold        <= (state_d == REFRACT);
      busy        <= (state_d == SPIKE) || (state_d == REFRACT);
      if (en) ts  <= ts + TS_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr      <= rd_ptr_d;
      fifo_cnt    <= fifo_cnt_d;
      spike_valid <= (fifo_cnt_d != '0);
      spike_time  <= spike_time_d;
      if (detect) spike_count <= sat_inc(spike_count);
      if (detect && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= ts;
  end

endmodule

// File: tb/tb_neuron_spike_ctrl.sv
// Bench for neuron_spike_ctrl: directed sequences with a timestamp scoreboard on the spike FIFO.
module tb_neuron_spike_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic signed [15:0] v_mem = '0;
  logic signed [15:0] v_thresh = '0;
  logic               spike_ready = 1'b0;
  logic               v_set, hold, busy, spike_valid, overflow;
  logic [23:0]        spike_time;
  logic [15:0]        spike_count;

  logic               rst_nr = 1'b1;
  logic               en_nr = 1'b0;
  logic signed [15:0] v_mem_nr = '0;
  logic signed [15:0] v_thresh_nr = '0;
  logic               spike_ready_nr = 1'b0;
  logic               v_set_nr, hold_nr, busy_nr, spike_valid_nr, overflow_nr;
  logic [23:0]        spike_time_nr;
  logic [15:0]        spike_count_nr;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  neuron_spike_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .v_mem(v_mem), .v_thresh(v_thresh),
    .v_set(v_set), .hold(hold), .busy(busy), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_time(spike_time),
    .spike_count(spike_count), .overflow(overflow)
  );

  neuron_spike_ctrl #(.REFRACT_CYCLES(0)) dut_nr (
    .clk(clk), .rst(rst_nr), .en(en_nr), .v_mem(v_mem_nr), .v_thresh(v_thresh_nr),
    .v_set(v_set_nr), .hold(hold_nr), .busy(busy_nr), .spike_valid(spike_valid_nr),
    .spike_ready(spike_ready_nr), .spike_time(spike_time_nr),
    .spike_count(spike_count_nr), .overflow(overflow_nr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted pop is compared with the oldest expected timestamp.
  always @(negedge clk) begin
    if (spike_valid === 1'b1 && spike_ready === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra_pop", 32'(spike_time), 32'hFFFF_FFFF);
      else                   check("sb_time", 32'(spike_time), exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; spike_ready = 1'b0; v_mem = '0;
    step();
    step();
    @(negedge clk);
    check("rst_vset", v_set, 0);
    check("rst_hold", hold, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", spike_valid, 0);
    check("rst_time", 32'(spike_time), 0);
    check("rst_count", 32'(spike_count), 0);
    check("rst_ovf", overflow, 0);
    exp_q.delete();
  endtask

  task automatic drain();
    int i;
    step();
    spike_ready = 1'b1;
    @(negedge clk);
    i = 0;
    while (spike_valid && i < 16) begin
      step();
      @(negedge clk);
      i++;
    end
    check("drain_valid", spike_valid, 0);
    check("drain_sb_left", exp_q.size(), 0);
    step();
    spike_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Ramp to threshold, full spike/refractory sequence.
    do_reset();
    v_thresh = 16'sd100;
    for (int k = 0; k <= 20; k++) begin
      step();
      if (k == 0) begin rst = 1'b0; en = 1'b1; end
      v_mem = (k <= 10) ? 16'(10 * k) : 16'sd0;
      if (k == 10) exp_q.push_back(32'd10);
      @(negedge clk);
      check("t1_vset", v_set, (k >= 11 && k <= 12));
      check("t1_hold", hold, (k >= 13 && k <= 17));
      check("t1_busy", busy, (k >= 11 && k <= 17));
      if (k == 11) begin
        check("t1_valid", spike_valid, 1);
        check("t1_time", 32'(spike_time), 10);
        check("t1_count", 32'(spike_count), 1);
      end
    end
    drain();
    check("t1_count_end", 32'(spike_count), 1);

    // No refractory: spikes every RESET_CYCLES+1 cycles, hold never asserted.
    step();
    rst_nr = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      if (k == 0) begin rst_nr = 1'b0; en_nr = 1'b1; v_thresh_nr = 16'sd100; end
      v_mem_nr = 16'sd150;
      @(negedge clk);
      check("t2_vset", v_set_nr, (k >= 2 && ((k - 2) % 3) != 2));
      check("t2_hold", hold_nr, 0);
      if (k == 12) begin
        check("t2_count", 32'(spike_count_nr), 4);
        check("t2_head", 32'(spike_time_nr), 1);
        check("t2_ovf", overflow_nr, 0);
      end
    end
    step();
    rst_nr = 1'b1; en_nr = 1'b0;

    // Six spikes into a stalled 4-deep FIFO: the first four survive, overflow sticks.
    do_reset();
    v_thresh = 16'sd100;
    for (int c = 0; c <= 50; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; en = 1'b1; end
      v_mem = (c <= 41) ? 16'sd150 : 16'sd0;
      if ((c % 8) == 1 && c <= 25) exp_q.push_back(32'(c));
      @(negedge clk);
      if (c == 26) check("t3_ovf_pre", overflow, 0);
      if (c == 34) check("t3_ovf_post", overflow, 1);
    end
    check("t3_ovf", overflow, 1);
    check("t3_count", 32'(spike_count), 6);
    check("t3_head", 32'(spike_time), 1);
    drain();

    // Full FIFO popped on the same edge as a new detection: nothing dropped.
    do_reset();
    v_thresh = 16'sd100;
    for (int c = 0; c <= 50; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; en = 1'b1; end
      v_mem = (c <= 33) ? 16'sd150 : 16'sd0;
      spike_ready = (c == 33);
      if ((c % 8) == 1 && c <= 33) exp_q.push_back(32'(c));
      @(negedge clk);
      if (c == 34) check("t4_head", 32'(spike_time), 9);
    end
    check("t4_ovf", overflow, 0);
    check("t4_count", 32'(spike_count), 5);
    drain();

    // en dropped in the first SPIKE cycle: sequence completes, timestamp frozen.
    do_reset();
    v_thresh = 16'sd100;
    for (int c = 0; c <= 30; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; spike_ready = 1'b1; end
      en = (c < 2 || c >= 15);
      v_mem = (c <= 16) ? 16'sd150 : 16'sd0;
      if (c == 1) exp_q.push_back(32'd1);
      if (c == 16) exp_q.push_back(32'd3);
      @(negedge clk);
      check("t5_vset", v_set, ((c >= 2 && c <= 3) || (c >= 17 && c <= 18)));
      check("t5_hold", hold, ((c >= 4 && c <= 8) || (c >= 19 && c <= 23)));
      check("t5_busy", busy, ((c >= 2 && c <= 8) || (c >= 17 && c <= 23)));
      if (c == 12) check("t5_count_idle", 32'(spike_count), 1);
    end
    check("t5_count", 32'(spike_count), 2);
    check("t5_sb_left", exp_q.size(), 0);
    step();
    spike_ready = 1'b0;

    // Reset during REFRACT, then a signed threshold crossing below zero.
    do_reset();
    v_thresh = 16'sd100;
    for (int c = 0; c <= 5; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; en = 1'b1; end
      v_mem = (c <= 1) ? 16'sd150 : 16'sd0;
      if (c == 1) exp_q.push_back(32'd1);
      if (c == 5) begin rst = 1'b1; exp_q.delete(); end
      @(negedge clk);
      if (c == 4) check("t6_hold_pre", hold, 1);
    end
    for (int c = 0; c <= 4; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; v_thresh = -16'sd60; end
      v_mem = (c < 2) ? -16'sd70 : ((c == 2) ? -16'sd50 : -16'sd100);
      if (c == 2) exp_q.push_back(32'd2);
      @(negedge clk);
      if (c == 0) begin
        check("t6_rst_vset", v_set, 0);
        check("t6_rst_hold", hold, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", 32'(spike_count), 0);
        check("t6_rst_valid", spike_valid, 0);
      end
      check("t6_vset", v_set, (c >= 3));
      if (c == 3) check("t6_count", 32'(spike_count), 1);
    end
    drain();

    // Negative voltage below a positive threshold, then positive above a negative one.
    do_reset();
    v_thresh = 16'sd100;
    for (int c = 0; c <= 13; c++) begin
      step();
      if (c == 0) begin rst = 1'b0; en = 1'b1; end
      v_thresh = (c < 10) ? 16'sd100 : -16'sd60;
      v_mem = (c < 10) ? -16'sd10 : ((c == 10) ? 16'sd50 : -16'sd100);
      if (c == 10) exp_q.push_back(32'd10);
      @(negedge clk);
      if (c == 10) check("t7_no_spike", 32'(spike_count), 0);
      if (c == 12) check("t7_spike", 32'(spike_count), 1);
      check("t7_vset", v_set, (c == 11 || c == 12));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/neuron_spike_ctrl.md
Name: neuron_spike_ctrl

Overview:
- Sequencing controller for the emulated exponential neuron datapath.
- Watches the fixed-point membrane voltage, detects threshold crossings, and drives the neuron's reset-select and integration-hold controls through a spike → reset → refractory sequence.
- Timestamps each spike and queues it in a small FIFO with a valid/ready handshake toward downstream spike consumers.

Parameters:
- WIDTH, 16: bit width of signed fixed-point voltage inputs (same format/exponent as the neuron V_out real).
- TS_W, 24: timestamp counter width.
- CNT_W, 16: spike counter width.
- RESET_CYCLES, 2: cycles v_set is held high per spike (1..255).
- REFRACT_CYCLES, 5: refractory hold cycles after reset (0..255; 0 skips refractory).
- FIFO_DEPTH, 4: spike event FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  emulator clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable; timestamp counts and detection occurs only while high.
- v_mem  in  WIDTH  signed membrane voltage from neuron.
- v_thresh  in  WIDTH  signed spike threshold, same format.
- v_set  out  1  selects reset voltage in neuron (digital select).
- hold  out  1  freezes neuron integration during refractory.
- busy  out  1  high in SPIKE or REFRACT.
- spike_valid  out  1  FIFO non-empty.
- spike_ready  in  1  consumer accepts head event.
- spike_time  out  TS_W  timestamp of head event.
- spike_count  out  CNT_W  total detected spikes, saturating.
- overflow  out  1  sticky: event dropped due to full FIFO.

Behaviour:
- Reset: state=IDLE, v_set=0, hold=0, busy=0, FIFO empty (spike_valid=0, spike_time=0), timestamp=0, spike_count=0, overflow=0. Reset mid-sequence aborts immediately; outputs return to reset values on the next edge.
- States: IDLE, INTEGRATE, SPIKE, REFRACT. All outputs are registered.
- IDLE: en=1 → INTEGRATE.
- INTEGRATE:
  - en=0 → IDLE.
  - Else if $signed(v_mem) >= $signed(v_thresh) → SPIKE.
  - On that edge: push event with the current timestamp; spike_count += 1, saturating at all-ones.
- SPIKE: v_set=1 for exactly RESET_CYCLES cycles, starting the cycle after detection. Then → REFRACT if REFRACT_CYCLES>0, else → INTEGRATE (or IDLE if en=0).
- REFRACT: hold=1 for exactly REFRACT_CYCLES cycles. Then → INTEGRATE if en=1, else IDLE.
- Deasserting en during SPIKE/REFRACT does not abort; the sequence completes, then the block goes to IDLE.
- Threshold compare is ignored outside INTEGRATE.
- Timestamp: increments by 1 every cycle en=1, in any state; wraps modulo 2^TS_W with no flag.
- FIFO:
  - First-word-fall-through; spike_time is valid whenever spike_valid=1.
  - Pop occurs when spike_valid && spike_ready.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: event dropped, overflow set (cleared only by rst), spike_count still increments.
  - spike_ready while empty: no effect.
  - spike_time holds its last value when the FIFO is empty.
- Latency: detection to v_set high is 1 cycle; detection to spike_valid (empty FIFO) is 1 cycle.

Test Plan:
- Reset, en=1, v_thresh=100, v_mem ramps 0,10,…,100 at t=10 → v_set high cycles 11–12, hold high 13–17, INTEGRATE at 18; spike_valid=1 with spike_time=10, spike_count=1.
- REFRACT_CYCLES=0, v_mem held at 150 with v_thresh=100 → repeated spikes every RESET_CYCLES+1=3 cycles; hold never asserted.
- spike_ready=0, trigger 6 spikes → first 4 timestamps retained in order, overflow=1, spike_count=6. Then drain with spike_ready=1 → 4 pops, spike_valid drops.
- FIFO full with spike_ready=1 on the same cycle as a new detection → no drop, overflow stays 0, order preserved.
- Deassert en during cycle 1 of SPIKE → full reset/refract sequence completes, then IDLE; timestamp frozen from en-low cycle; a new crossing is not detected.
- Assert rst during REFRACT → v_set=hold=busy=0, spike_count=0, FIFO empty next cycle; negative v_mem=-50 with v_thresh=-60 → spike (signed compare).
